// File: rtl/mux2a1class_arb_pkg.sv
// mux2a1class_arb_pkg: word layout and arbiter state encoding.
// These definitions are shared with the class demux and the class FIFOs.
// Word layout: bit9 = class, bit8 = dest, bits7:0 = payload.
package mux2a1class_arb_pkg;
  localparam int DATA_W    = 10;
  localparam int CLASS_BIT = 9;
  localparam int DEST_BIT  = 8;
  localparam int PAYLOAD_W = 8;

  typedef enum logic {SERVE0 = 1'b0, SERVE1 = 1'b1} arb_state_t;

  typedef struct packed {
    logic                 cls;
    logic                 dest;
    logic [PAYLOAD_W-1:0] payload;
  } word_t;

  // True when the class field of a word matches the FIFO it came from.
  function automatic logic class_ok(input logic [DATA_W-1:0] w, input logic k);
    return w[CLASS_BIT] == k;
  endfunction
endpackage

// File: rtl/mux2a1class_arb_if.sv
// mux2a1class_arb_if: bus bundle for the class recombiner.
// Contents:
//   - Class-0 / class-1 FIFO heads (data, empty) and their pops.
//   - Downstream backpressure (full_in).
//   - Registered output word and its valid pulse.
//   - Sticky class error flag and per-class forwarded-word counters.
// Modports:
//   - slave:  the arbiter side.
//   - master: the FIFO / egress side.
interface mux2a1class_arb_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] fifo0_data;
  logic              fifo0_empty;
  logic              fifo0_pop;
  logic [DATA_W-1:0] fifo1_data;
  logic              fifo1_empty;
  logic              fifo1_pop;
  logic              full_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              err_class;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, full_in,
    output fifo0_pop, fifo1_pop, data_out, valid_out, err_class, cnt0, cnt1
  );

  modport master (
    output fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, full_in,
    input  fifo0_pop, fifo1_pop, data_out, valid_out, err_class, cnt0, cnt1
  );
endinterface

// File: rtl/mux2a1class_arb_rr_weight_arb.sv
// rr_weight_arb: weighted round-robin choice between two class FIFOs.
// Ports:
//   - clk, reset_L:   clock and asynchronous active-low reset.
//   - empty0, empty1: FIFO empty flags.
//   - full:           downstream backpressure; blocks every grant.
//   - grant0, grant1: combinational one-hot grants, used directly as pops.
module rr_weight_arb
  import mux2a1class_arb_pkg::*;
#(
  parameter int WEIGHT0 = 2,
  parameter int WEIGHT1 = 1
) (
  input  logic clk,
  input  logic reset_L,
  input  logic empty0,
  input  logic empty1,
  input  logic full,
  output logic grant0,
  output logic grant1
);
  arb_state_t state, state_n, other;
  logic [3:0] burst, burst_n, inc, wt;
  logic own_empty, oth_empty, go, serve_own, serve_oth, switch_own;

  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state <= SERVE0;
      burst <= '0;
    end else begin
      state <= state_n;
      burst <= burst_n;
    end

  // The current state's class is served first. The other class is taken
  // only when the own FIFO is empty, and that also moves the state over.
  // After a grant, the burst count saturates at the weight. Once it reaches
  // the weight and the other class is waiting, the state hands over.
  always_comb begin
    other      = state == SERVE0 ? SERVE1 : SERVE0;
    own_empty  = state == SERVE0 ? empty0 : empty1;
    oth_empty  = state == SERVE0 ? empty1 : empty0;
    wt         = state == SERVE0 ? 4'(WEIGHT0) : 4'(WEIGHT1);
    go         = reset_L & ~full;
    serve_own  = go & ~own_empty;
    serve_oth  = go & own_empty & ~oth_empty;
    inc        = burst == wt ? burst : burst + 4'd1;
    switch_own = serve_own & (inc == wt) & ~oth_empty;
    state_n    = (switch_own | serve_oth) ? other : state;
    burst_n    = (switch_own | serve_oth) ? 4'd0 : serve_own ? inc : burst;
    grant0     = state == SERVE0 ? serve_own : serve_oth;
    grant1     = state == SERVE1 ? serve_own : serve_oth;
  end
endmodule

// File: rtl/mux2a1class_arb.sv
// mux2a1class_arb: merges the class-0 and class-1 FIFO streams into one word stream.
// Ports:
//   - clk, reset_L: clock and asynchronous active-low reset.
//   - bus (slave):  FIFO heads and pops, full_in, and the registered outputs
//                   data_out / valid_out, err_class, cnt0 and cnt1.
// Behaviour:
//   - A popped word appears on data_out with valid_out one cycle later.
//   - A word whose class bit disagrees with its source FIFO is dropped and
//     sets err_class, which stays set until reset.
module mux2a1class_arb
  import mux2a1class_arb_pkg::*;
#(
  parameter int WEIGHT0 = 2,
  parameter int WEIGHT1 = 1,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_L,
  mux2a1class_arb_if.slave bus
);
  logic              grant0, grant1, take, fwd;
  logic [DATA_W-1:0] word, data_q;
  logic              valid_q, err_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  rr_weight_arb #(.WEIGHT0(WEIGHT0), .WEIGHT1(WEIGHT1)) u_arb (
    .clk    (clk),
    .reset_L(reset_L),
    .empty0 (bus.fifo0_empty),
    .empty1 (bus.fifo1_empty),
    .full   (bus.full_in),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.fifo0_pop = grant0;
  assign bus.fifo1_pop = grant1;
  assign take          = grant0 | grant1;
  assign word          = grant1 ? bus.fifo1_data : bus.fifo0_data;
  // A mis-classed word is still popped and still counts as an arbiter grant.
  assign fwd           = take & class_ok(word, grant1);

  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      valid_q <= fwd;
      if (fwd) data_q <= word;
      if (take && !fwd) err_q <= 1'b1;
      if (fwd && !grant1) cnt0_q <= cnt0_q + 1'b1;
      if (fwd && grant1) cnt1_q <= cnt1_q + 1'b1;
    end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.err_class = err_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_mux2a1class_arb.sv
// tb_mux2a1class_arb: directed vectors and corner sequences for mux2a1class_arb.
module tb_mux2a1class_arb;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  mux2a1class_arb_if bus();
  mux2a1class_arb dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic       full;
    logic       p0;
    logic       p1;
    logic       v;
    logic [9:0] d;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t       tbl[13];
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int         tests = 0;
  int         fails = 0;
  logic       s_p0, s_p1;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo0_empty = q0.size() == 0;
    bus.fifo0_data  = q0.size() != 0 ? q0[0] : 10'h0;
    bus.fifo1_empty = q1.size() == 0;
    bus.fifo1_data  = q1.size() != 0 ? q1[0] : 10'h0;
  endtask

  // Pops are sampled mid-cycle; the registered outputs are read 1 after the edge.
  task automatic tick(input logic f);
    bus.full_in = f;
    @(negedge clk);
    s_p0 = bus.fifo0_pop;
    s_p1 = bus.fifo1_pop;
    @(posedge clk);
    #1;
    if (s_p0 && q0.size() != 0) void'(q0.pop_front());
    if (s_p1 && q1.size() != 0) void'(q1.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    q0.delete();
    q1.delete();
    refresh();
    #2;
    reset_L = 1'b1;
  endtask

  int nvalid;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h001, 8'd1, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h002, 8'd2, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h201, 8'd2, 8'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h003, 8'd3, 8'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h003, 8'd3, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h003, 8'd3, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h003, 8'd3, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 8'd4, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h202, 8'd4, 8'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h005, 8'd5, 8'd2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h006, 8'd6, 8'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h203, 8'd6, 8'd3};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h203, 8'd6, 8'd3};

    bus.full_in = 1'b0;
    q0.push_back(10'h0A5);
    q0.push_back(10'h13C);
    refresh();
    repeat (2) @(posedge clk);
    #1;
    chk("rst pop0", bus.fifo0_pop, 0);
    chk("rst valid", bus.valid_out, 0);
    chk("rst data", bus.data_out, 0);
    chk("rst cnt0", bus.cnt0, 0);
    chk("rst err", bus.err_class, 0);
    reset_L = 1'b1;

    tick(1'b0);
    chk("c0only pop0 1", s_p0, 1);
    chk("c0only out 1", {bus.valid_out, bus.data_out}, {1'b1, 10'h0A5});
    tick(1'b0);
    chk("c0only pop0 2", s_p0, 1);
    chk("c0only out 2", {bus.valid_out, bus.data_out}, {1'b1, 10'h13C});
    tick(1'b0);
    chk("c0only idle pop", {s_p0, s_p1}, 0);
    chk("c0only idle valid", bus.valid_out, 0);
    chk("c0only cnt0", bus.cnt0, 2);

    do_reset();
    for (int i = 1; i <= 6; i++) q0.push_back(10'(i));
    for (int i = 1; i <= 3; i++) q1.push_back(10'h200 + 10'(i));
    refresh();
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].full);
      chk($sformatf("row%0d pop0", i), s_p0, tbl[i].p0);
      chk($sformatf("row%0d pop1", i), s_p1, tbl[i].p1);
      chk($sformatf("row%0d valid", i), bus.valid_out, tbl[i].v);
      chk($sformatf("row%0d data", i), bus.data_out, tbl[i].d);
      chk($sformatf("row%0d cnt0", i), bus.cnt0, tbl[i].c0);
      chk($sformatf("row%0d cnt1", i), bus.cnt1, tbl[i].c1);
    end

    q1.push_back(10'h055);
    q1.push_back(10'h2AA);
    refresh();
    tick(1'b0);
    chk("bad pop1", s_p1, 1);
    chk("bad valid", bus.valid_out, 0);
    chk("bad err", bus.err_class, 1);
    chk("bad cnt1", bus.cnt1, 3);
    tick(1'b0);
    chk("good pop1", s_p1, 1);
    chk("good out", {bus.valid_out, bus.data_out}, {1'b1, 10'h2AA});
    chk("good cnt1", bus.cnt1, 4);
    chk("good err sticky", bus.err_class, 1);
    tick(1'b0);
    chk("post err sticky", bus.err_class, 1);
    chk("post valid", bus.valid_out, 0);

    q0.push_back(10'h011);
    q0.push_back(10'h012);
    q0.push_back(10'h013);
    refresh();
    tick(1'b0);
    chk("pre-rst out", {bus.valid_out, bus.data_out}, {1'b1, 10'h011});
    #2;
    reset_L = 1'b0;
    #1;
    chk("async valid", bus.valid_out, 0);
    chk("async data", bus.data_out, 0);
    chk("async cnts", {bus.cnt0, bus.cnt1}, 0);
    chk("async err", bus.err_class, 0);
    chk("async pops", {bus.fifo0_pop, bus.fifo1_pop}, 0);
    reset_L = 1'b1;
    chk("release valid", bus.valid_out, 0);
    tick(1'b0);
    chk("restart pop0", s_p0, 1);
    chk("restart out", {bus.valid_out, bus.data_out}, {1'b1, 10'h012});
    chk("restart cnt0", bus.cnt0, 1);

    do_reset();
    for (int i = 0; i < 257; i++) q0.push_back(10'h100 | 10'(i[7:0]));
    refresh();
    nvalid = 0;
    for (int i = 0; i < 257; i++) begin
      tick(1'b0);
      if (bus.valid_out) nvalid++;
    end
    chk("wrap nvalid", nvalid, 257);
    chk("wrap cnt0", bus.cnt0, 1);
    chk("wrap last data", bus.data_out, 10'h100);
    tick(1'b0);
    chk("wrap drained", {s_p0, bus.valid_out}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux2a1class_arb.md
Name: mux2a1class_arb

Overview:
- Recombines the two class streams produced by the class demux into one 10-bit word stream toward the egress port.
- Each class stream arrives from a first-word-fall-through class FIFO.
- A weighted round-robin FSM chooses the class, pops the chosen FIFO, and registers the word onto the output under downstream backpressure.
- Also checks that each word's class bit matches its source and counts forwarded words per class.

Parameters:
- DATA_W, 10, word width: bit9 = class, bit8 = dest, bits7:0 = payload.
- WEIGHT0, 2, maximum consecutive class-0 grants while class 1 is waiting (1..15).
- WEIGHT1, 1, maximum consecutive class-1 grants while class 0 is waiting (1..15).
- CNT_W, 8, width of the per-class forwarded-word counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- fifo0_data  input  DATA_W  head word of the class-0 FIFO (fall-through).
- fifo0_empty  input  1  class-0 FIFO empty.
- fifo0_pop  output  1  pop class-0 FIFO, combinational.
- fifo1_data  input  DATA_W  head word of the class-1 FIFO.
- fifo1_empty  input  1  class-1 FIFO empty.
- fifo1_pop  output  1  pop class-1 FIFO, combinational.
- full_in  input  1  downstream cannot accept a word this cycle.
- data_out  output  DATA_W  registered output word.
- valid_out  output  1  data_out is valid this cycle (one-cycle pulse per word).
- err_class  output  1  sticky: a word's class bit mismatched its source FIFO.
- cnt0, cnt1  output  CNT_W  forwarded words per class.

Behaviour:
- Reset (async assert, sync release): data_out = 0, valid_out = 0, err_class = 0, cnt0 = cnt1 = 0, state = SERVE0, burst counter = 0. While reset_L = 0, fifo0_pop and fifo1_pop are 0.
- Grant condition: grant allowed only when full_in = 0. At most one pop per cycle, never to an empty FIFO.
- FSM states:
  - SERVE0: grant class 0 if not empty. Otherwise grant class 1 if not empty, and go to SERVE1.
  - SERVE1: symmetric to SERVE0.
- Burst counter:
  - Counts consecutive grants in the current state.
  - In SERVE0, when count reaches WEIGHT0 and class 1 is non-empty, go to SERVE1 and clear the count.
  - If the other class is empty, stay in the current state and saturate the count at its weight.
  - Count clears on every state change.
- Idle and stall:
  - full_in = 1: no pop, no state or counter change, valid_out = 0 next cycle, data_out holds.
  - Both FIFOs empty: no pop, state holds, valid_out = 0 next cycle.
- Latency: a word popped in cycle N appears on data_out with valid_out = 1 in cycle N+1.
  - A word is never lost or duplicated across a full_in rise, because the grant decision already includes full_in.
  - Downstream must be able to absorb one word in the cycle after it raises full_in.
- Class check: popped word from FIFO k with bit9 != k:
  - The word is dropped: valid_out = 0 next cycle, counter unchanged.
  - err_class is set and stays set until reset.
  - Arbitration still counts the grant.
- Counters: cnt0 / cnt1 increment on each forwarded word and wrap modulo 2^CNT_W.
- Reset mid-operation: all state clears immediately. A word registered but not yet taken is discarded; upstream FIFO contents are untouched.

Decomposition:
- Shared package (class_pkg): DATA_W, CLASS_BIT = 9, DEST_BIT = 8, PAYLOAD_W = 8, FSM state encoding {SERVE0, SERVE1}. These are shared with the class demux and the class FIFOs.
- One natural sub-module: rr_weight_arb (FSM + burst counter, producing grant0 / grant1). The datapath, class check and counters stay in the top module.

Test Plan:
- Only fifo0 non-empty with words 0x0A5, 0x13C; full_in = 0 -> fifo0_pop in cycles 1–2; data_out 0x0A5 then 0x13C with valid_out in cycles 2–3; cnt0 = 2, state stays SERVE0.
- Both FIFOs full (class-0 words 0x001..0x006, class-1 words 0x201..), WEIGHT0 = 2, WEIGHT1 = 1 -> output order 0x001, 0x002, 0x201, 0x003, 0x004, 0x202, …
- full_in = 1 for 3 cycles mid-burst -> no pops, valid_out = 0 for 3 cycles, no word lost; sequence resumes in order when full_in falls.
- fifo1 presents 0x055 (bit9 = 0) -> popped, not output, err_class = 1 and stays 1, cnt1 unchanged; the next valid class-1 word forwards normally.
- Push 257 class-0 words with CNT_W = 8 -> cnt0 = 1.
- reset_L pulled low asynchronously between clock edges during traffic -> all outputs zero immediately; after release, output restarts from SERVE0 with no stale valid_out.
